// File: rtl/taxi_pkg.sv
// taxi_pkg: trip/stage enums and saturating add shared by the taxi meter
package taxi_pkg;
  typedef enum logic [1:0] {VACANT = 2'd0, MOVING = 2'd1, WAITING = 2'd2, PAY = 2'd3} trip_state_t;
  typedef enum logic [1:0] {STAGE_1, STAGE_2, STAGE_3} stage_t;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction
endpackage

// File: rtl/taxi_meter_fsm_tick_counter.sv
// taxi_tick_counter: count-to-N with enable/hold/clear, one-cycle tick on wrap
module taxi_tick_counter #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && !i_clr && r_cnt == W'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/taxi_meter_fsm.sv
// taxi_meter_fsm: trip FSM with staged distance/wait tariffs and saturating totals
// Optional night surcharge (+25% per increment) enabled by TAXI_NIGHT_SURCHARGE_EN.
module taxi_meter_fsm
  import taxi_pkg::*;
#(
  parameter int DW                 = 32,
  parameter int INITIAL_PRICE      = 80,
  parameter int BORDER_1ST         = 400,
  parameter int BORDER_2ND         = 1000,
  parameter int PRICE_DISTANCE_1ST = 0,
  parameter int PRICE_DISTANCE_2ND = 14,
  parameter int PRICE_DISTANCE_3RD = 20,
  parameter int PRICE_WAIT_1ST     = 0,
  parameter int PRICE_WAIT_2ND     = 7,
  parameter int PRICE_WAIT_3RD     = 10,
  parameter int CNT_500M           = 50,
  parameter int CNT_6S             = 6000,
  parameter int CNT_3MIN           = 180000,
  parameter int CNT_1S             = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          distance_pulse_10m,
  input  logic          hire_start,
  input  logic          hire_end,
  input  logic          clear,
  input  logic          night,
  output logic [1:0]    state,
  output logic [DW-1:0] distance,
  output logic [DW-1:0] wait_time,
  output logic [DW-1:0] fare,
  output logic          fare_valid
);
  trip_state_t   r_state, w_state_nx;
  logic          r_pulse_d;
  logic [DW-1:0] r_distance, r_wait_time, r_fare, w_dist_nx;
  logic          w_hired, w_edge, w_start;
  logic          w_tick_500m, w_tick_idle, w_tick_3min, w_tick_1s;
  logic [63:0]   w_dbase, w_wbase, w_dinc, w_winc;

  function automatic stage_t stage_of(input logic [DW-1:0] d);
    return 64'(d) <= 64'(BORDER_1ST) ? STAGE_1 : 64'(d) <= 64'(BORDER_2ND) ? STAGE_2 : STAGE_3;
  endfunction

  function automatic logic [63:0] price(input stage_t s, input int p1, input int p2, input int p3);
    return 64'(s == STAGE_1 ? p1 : s == STAGE_2 ? p2 : p3);
  endfunction

  assign w_hired   = r_state == MOVING || r_state == WAITING;
  assign w_edge    = w_hired && distance_pulse_10m && !r_pulse_d;
  assign w_start   = r_state == VACANT && hire_start;
  assign w_dist_nx = DW'(sat_add(64'(r_distance), 64'(w_edge), DW));
  // distance tariff uses the post-increment distance, wait tariff the current one
  assign w_dbase   = w_tick_500m ? price(stage_of(w_dist_nx), PRICE_DISTANCE_1ST, PRICE_DISTANCE_2ND, PRICE_DISTANCE_3RD) : 64'd0;
  assign w_wbase   = w_tick_3min ? price(stage_of(r_distance), PRICE_WAIT_1ST, PRICE_WAIT_2ND, PRICE_WAIT_3RD) : 64'd0;
`ifdef TAXI_NIGHT_SURCHARGE_EN
  assign w_dinc = night ? w_dbase + (w_dbase >> 2) : w_dbase;
  assign w_winc = night ? w_wbase + (w_wbase >> 2) : w_wbase;
`else
  logic w_unused_night;
  assign w_unused_night = night;
  assign w_dinc = w_dbase;
  assign w_winc = w_wbase;
`endif

  taxi_tick_counter #(.N(CNT_500M)) u_500m (.clk(clk), .rst_n(rst_n), .i_en(w_edge), .i_clr(w_start), .o_tick(w_tick_500m));
  taxi_tick_counter #(.N(CNT_6S)) u_idle (.clk(clk), .rst_n(rst_n), .i_en(r_state == MOVING && !w_edge), .i_clr(w_start || w_edge), .o_tick(w_tick_idle));
  taxi_tick_counter #(.N(CNT_3MIN)) u_3min (.clk(clk), .rst_n(rst_n), .i_en(r_state == WAITING), .i_clr(w_start), .o_tick(w_tick_3min));
  taxi_tick_counter #(.N(CNT_1S)) u_1s (.clk(clk), .rst_n(rst_n), .i_en(r_state == WAITING), .i_clr(w_start), .o_tick(w_tick_1s));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      VACANT:  w_state_nx = hire_start ? MOVING : VACANT;
      MOVING:  w_state_nx = hire_end ? PAY : w_tick_idle ? WAITING : MOVING;
      WAITING: w_state_nx = hire_end ? PAY : w_edge ? MOVING : WAITING;
      PAY:     w_state_nx = clear ? VACANT : PAY;
      default: w_state_nx = VACANT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= VACANT;
      r_pulse_d   <= 1'b0;
      r_distance  <= '0;
      r_wait_time <= '0;
      r_fare      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pulse_d <= distance_pulse_10m;
      if (w_start) begin
        r_distance  <= '0;
        r_wait_time <= '0;
        r_fare      <= DW'(INITIAL_PRICE);
      end else if (r_state == PAY && clear) begin
        r_distance  <= '0;
        r_wait_time <= '0;
        r_fare      <= '0;
      end else if (w_hired) begin
        r_distance  <= w_dist_nx;
        r_wait_time <= DW'(sat_add(64'(r_wait_time), 64'(w_tick_1s), DW));
        r_fare      <= DW'(sat_add(sat_add(64'(r_fare), w_dinc, DW), w_winc, DW));
      end
    end

  assign state      = r_state;
  assign distance   = r_distance;
  assign wait_time  = r_wait_time;
  assign fare       = r_fare;
  assign fare_valid = r_state == PAY;
endmodule
